// File: rtl/alu_op_sequencer.sv
// Hardwired control sequencer for the Phase-1 CPU datapath.
// Walks the fetch steps T0-T2, then decodes the IR opcode into a short
// execute sequence of one-hot register strobes and an ALU opcode.
// All outputs are a Moore decode of the registered state plus the IR fields.
module alu_op_sequencer #(
  parameter int MEM_WAIT = 0
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] ir,
  output logic        PCout,
  output logic        MARin,
  output logic        IncPC,
  output logic        memRead,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        HIin,
  output logic        LOin,
  output logic [15:0] Rout,
  output logic [15:0] Rin,
  output logic [4:0]  alu_op,
  output logic        done,
  output logic        illegal
);

  typedef enum logic [3:0] {
    IDLE, T0, T1, T2, T3, T4, T5, T6, DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [2:0] wait_cnt;

  logic [4:0] opcode;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] rc;
  logic       is_three;
  logic       is_unary;
  logic       is_muldiv;
  logic       unused_ir_bits;

  assign opcode = ir[31:27];
  assign ra     = ir[26:23];
  assign rb     = ir[22:19];
  assign rc     = ir[18:15];

  // Low IR bits carry immediates the execute sequences here never consume.
  assign unused_ir_bits = ^ir[14:0];

  // Opcode classes: add..shl are contiguous, unary is neg/not, mul/div pair.
  assign is_three  = (opcode >= 5'b00011) && (opcode <= 5'b01011);
  assign is_unary  = (opcode == 5'b10001) || (opcode == 5'b10010);
  assign is_muldiv = (opcode == 5'b10000) || (opcode == 5'b01111);

  // State register; clear drops straight back to IDLE even mid-instruction.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Memory wait counter: armed while in T0 so it holds MEM_WAIT on T1 entry.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      wait_cnt <= 3'd0;
    end else if (state == T0) begin
      wait_cnt <= 3'(MEM_WAIT);
    end else if ((state == T1) && (wait_cnt != 3'd0)) begin
      wait_cnt <= wait_cnt - 3'd1;
    end
  end

  // Next-state sequencing through fetch and the opcode-specific execute path.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = T0;
      T0:   state_next = T1;
      T1:   if (wait_cnt == 3'd0) state_next = T2;
      T2:   state_next = T3;
      T3: begin
        if (is_three || is_unary || is_muldiv) state_next = T4;
        else                                   state_next = IDLE;
      end
      T4: begin
        if (is_unary) state_next = DONE;
        else          state_next = T5;
      end
      T5: begin
        if (is_muldiv) state_next = T6;
        else           state_next = DONE;
      end
      T6:   state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobe decode: each step drives at most one Rout and one Rin bit.
  always_comb begin
    PCout    = 1'b0;
    MARin    = 1'b0;
    IncPC    = 1'b0;
    memRead  = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    Zhighout = 1'b0;
    Zlowout  = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    Rout     = 16'd0;
    Rin      = 16'd0;
    alu_op   = 5'd0;
    done     = 1'b0;
    illegal  = 1'b0;
    case (state)
      T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
      end
      T1: begin
        memRead = 1'b1;
        MDRin   = 1'b1;
      end
      T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      T3: begin
        if (is_three) begin
          Rout = 16'd1 << rb;
          Yin  = 1'b1;
        end else if (is_unary) begin
          Rout   = 16'd1 << rb;
          Zin    = 1'b1;
          alu_op = opcode;
        end else if (is_muldiv) begin
          Rout = 16'd1 << ra;
          Yin  = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      T4: begin
        if (is_three) begin
          Rout   = 16'd1 << rc;
          Zin    = 1'b1;
          alu_op = opcode;
        end else if (is_unary) begin
          Zlowout = 1'b1;
          Rin     = 16'd1 << ra;
        end else if (is_muldiv) begin
          Rout   = 16'd1 << rb;
          Zin    = 1'b1;
          alu_op = opcode;
        end
      end
      T5: begin
        if (is_three) begin
          Zlowout = 1'b1;
          Rin     = 16'd1 << ra;
        end else if (is_muldiv) begin
          Zlowout = 1'b1;
          LOin    = 1'b1;
        end
      end
      T6: begin
        if (is_muldiv) begin
          Zhighout = 1'b1;
          HIin     = 1'b1;
        end
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: per-cycle expected strobe
// bundles are queued when an instruction is launched and compared as the
// sequencer steps through fetch and execute.
module tb_alu_op_sequencer;

  typedef struct packed {
    logic        pc_out;
    logic        mar_in;
    logic        inc_pc;
    logic        mem_read;
    logic        mdr_in;
    logic        mdr_out;
    logic        ir_in;
    logic        y_in;
    logic        z_in;
    logic        zhigh_out;
    logic        zlow_out;
    logic        hi_in;
    logic        lo_in;
    logic [15:0] r_out;
    logic [15:0] r_in;
    logic [4:0]  alu_op;
    logic        done;
    logic        illegal;
  } obs_t;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic [31:0] ir    = 32'd0;

  logic PCout0, MARin0, IncPC0, memRead0, MDRin0, MDRout0, IRin0;
  logic Yin0, Zin0, Zhighout0, Zlowout0, HIin0, LOin0, done0, illegal0;
  logic [15:0] Rout0, Rin0;
  logic [4:0]  alu_op0;

  logic PCout2, MARin2, IncPC2, memRead2, MDRin2, MDRout2, IRin2;
  logic Yin2, Zin2, Zhighout2, Zlowout2, HIin2, LOin2, done2, illegal2;
  logic [15:0] Rout2, Rin2;
  logic [4:0]  alu_op2;

  obs_t obs_w0;
  obs_t obs_w2;
  obs_t exp_q[$];

  int error_count = 0;
  int check_count = 0;

  assign obs_w0 = {PCout0, MARin0, IncPC0, memRead0, MDRin0, MDRout0, IRin0,
                   Yin0, Zin0, Zhighout0, Zlowout0, HIin0, LOin0,
                   Rout0, Rin0, alu_op0, done0, illegal0};
  assign obs_w2 = {PCout2, MARin2, IncPC2, memRead2, MDRin2, MDRout2, IRin2,
                   Yin2, Zin2, Zhighout2, Zlowout2, HIin2, LOin2,
                   Rout2, Rin2, alu_op2, done2, illegal2};

  alu_op_sequencer #(.MEM_WAIT(0)) dut_w0 (
    .clock(clock), .clear(clear), .start(start), .ir(ir),
    .PCout(PCout0), .MARin(MARin0), .IncPC(IncPC0),
    .memRead(memRead0), .MDRin(MDRin0), .MDRout(MDRout0), .IRin(IRin0),
    .Yin(Yin0), .Zin(Zin0), .Zhighout(Zhighout0), .Zlowout(Zlowout0),
    .HIin(HIin0), .LOin(LOin0), .Rout(Rout0), .Rin(Rin0),
    .alu_op(alu_op0), .done(done0), .illegal(illegal0)
  );

  alu_op_sequencer #(.MEM_WAIT(2)) dut_w2 (
    .clock(clock), .clear(clear), .start(start), .ir(ir),
    .PCout(PCout2), .MARin(MARin2), .IncPC(IncPC2),
    .memRead(memRead2), .MDRin(MDRin2), .MDRout(MDRout2), .IRin(IRin2),
    .Yin(Yin2), .Zin(Zin2), .Zhighout(Zhighout2), .Zlowout(Zlowout2),
    .HIin(HIin2), .LOin(LOin2), .Rout(Rout2), .Rin(Rin2),
    .alu_op(alu_op2), .done(done2), .illegal(illegal2)
  );

  // Free-running 10-time-unit clock.
  always #5 clock = ~clock;

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] make_ir(input logic [4:0] op, input logic [3:0] a,
                                          input logic [3:0] b, input logic [3:0] c);
    return {op, a, b, c, 15'd0};
  endfunction

  task automatic checkOutput(input string tag, input obs_t actual, input obs_t expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Fetch expectations: T0, T1 held for MEM_WAIT extra cycles, then T2.
  task automatic push_fetch(input int waits);
    obs_t e;
    e = '0; e.pc_out = 1'b1; e.mar_in = 1'b1; e.inc_pc = 1'b1;
    exp_q.push_back(e);
    e = '0; e.mem_read = 1'b1; e.mdr_in = 1'b1;
    repeat (waits + 1) exp_q.push_back(e);
    e = '0; e.mdr_out = 1'b1; e.ir_in = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic push_unary(input int waits, input logic [4:0] op,
                            input logic [15:0] src, input logic [15:0] dst);
    obs_t e;
    push_fetch(waits);
    e = '0; e.r_out = src; e.z_in = 1'b1; e.alu_op = op; exp_q.push_back(e);
    e = '0; e.zlow_out = 1'b1; e.r_in = dst;             exp_q.push_back(e);
    e = '0; e.done = 1'b1;                               exp_q.push_back(e);
    e = '0;                                              exp_q.push_back(e);
  endtask

  task automatic push_three(input logic [4:0] op, input logic [15:0] srcb,
                            input logic [15:0] srcc, input logic [15:0] dst);
    obs_t e;
    push_fetch(0);
    e = '0; e.r_out = srcb; e.y_in = 1'b1;                exp_q.push_back(e);
    e = '0; e.r_out = srcc; e.z_in = 1'b1; e.alu_op = op; exp_q.push_back(e);
    e = '0; e.zlow_out = 1'b1; e.r_in = dst;              exp_q.push_back(e);
    e = '0; e.done = 1'b1;                                exp_q.push_back(e);
    e = '0;                                               exp_q.push_back(e);
  endtask

  task automatic push_muldiv(input logic [4:0] op, input logic [15:0] srca,
                             input logic [15:0] srcb);
    obs_t e;
    push_fetch(0);
    e = '0; e.r_out = srca; e.y_in = 1'b1;                exp_q.push_back(e);
    e = '0; e.r_out = srcb; e.z_in = 1'b1; e.alu_op = op; exp_q.push_back(e);
    e = '0; e.zlow_out = 1'b1; e.lo_in = 1'b1;            exp_q.push_back(e);
    e = '0; e.zhigh_out = 1'b1; e.hi_in = 1'b1;           exp_q.push_back(e);
    e = '0; e.done = 1'b1;                                exp_q.push_back(e);
    e = '0;                                               exp_q.push_back(e);
  endtask

  task automatic push_illegal();
    obs_t e;
    push_fetch(0);
    e = '0; e.illegal = 1'b1; exp_q.push_back(e);
    e = '0;                   exp_q.push_back(e);
    e = '0;                   exp_q.push_back(e);
  endtask

  // Launch one instruction and score each following cycle against the queue.
  // start stays high for 'hold' observed cycles; max_obs cuts the run short.
  task automatic applyStimulus(input string name, input logic [31:0] ir_val,
                               input int hold, input bit use_w2, input int max_obs);
    obs_t expected;
    @(negedge clock);
    ir    = ir_val;
    start = 1'b1;
    for (int i = 0; i < max_obs && exp_q.size() > 0; i++) begin
      @(negedge clock);
      expected = exp_q.pop_front();
      checkOutput($sformatf("%s[%0d]", name, i), use_w2 ? obs_w2 : obs_w0, expected);
      start = (i + 1 < hold);
    end
    start = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    $display("[TB] alu_op_sequencer bench starting");

    // Reset state: everything low while clear is held.
    #1 clear = 1'b1;
    #2;
    checkOutput("reset_w0", obs_w0, obs_t'('0));
    checkOutput("reset_w2", obs_w2, obs_t'('0));
    @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
    checkOutput("idle_w0", obs_w0, obs_t'('0));

    push_unary(0, 5'b10001, 16'h0080, 16'h0040);
    applyStimulus("neg", 32'h8B38_0000, 1, 1'b0, 100);

    push_three(5'b00011, 16'h0004, 16'h0008, 16'h0002);
    applyStimulus("add", 32'h1891_8000, 1, 1'b0, 100);

    push_muldiv(5'b10000, 16'h0010, 16'h0020);
    applyStimulus("mul", 32'h8228_0000, 1, 1'b0, 100);

    push_illegal();
    applyStimulus("ill_f8", 32'hF800_0000, 1, 1'b0, 100);

    push_illegal();
    applyStimulus("ill_00", make_ir(5'b00000, 4'd1, 4'd2, 4'd3), 1, 1'b0, 100);

    push_unary(0, 5'b10010, 16'h0200, 16'h0004);
    applyStimulus("not", make_ir(5'b10010, 4'd2, 4'd9, 4'd0), 1, 1'b0, 100);

    push_unary(0, 5'b10001, 16'h0008, 16'h0008);
    applyStimulus("neg_same", make_ir(5'b10001, 4'd3, 4'd3, 4'd0), 1, 1'b0, 100);

    push_three(5'b01011, 16'h0001, 16'h4000, 16'h8000);
    applyStimulus("shl", make_ir(5'b01011, 4'd15, 4'd0, 4'd14), 1, 1'b0, 100);

    push_three(5'b00111, 16'h0020, 16'h0040, 16'h0010);
    applyStimulus("ror", make_ir(5'b00111, 4'd4, 4'd5, 4'd6), 1, 1'b0, 100);

    push_muldiv(5'b01111, 16'h0080, 16'h0100);
    applyStimulus("div", make_ir(5'b01111, 4'd7, 4'd8, 4'd0), 1, 1'b0, 100);

    // Memory wait: the MEM_WAIT=2 instance stretches T1 to three cycles.
    repeat (4) @(negedge clock);
    push_unary(2, 5'b10001, 16'h0080, 16'h0040);
    applyStimulus("neg_w2", 32'h8B38_0000, 1, 1'b1, 100);

    // start held through DONE: the second instruction begins only from IDLE.
    repeat (4) @(negedge clock);
    push_unary(0, 5'b10001, 16'h0080, 16'h0040);
    push_unary(0, 5'b10001, 16'h0080, 16'h0040);
    applyStimulus("neg_held", 32'h8B38_0000, 8, 1'b0, 100);

    // Asynchronous clear in the middle of T4 of ADD.
    repeat (4) @(negedge clock);
    push_three(5'b00011, 16'h0004, 16'h0008, 16'h0002);
    applyStimulus("clr_add", 32'h1891_8000, 1, 1'b0, 5);
    #2 clear = 1'b1;
    #1;
    checkOutput("clr_async", obs_w0, obs_t'('0));
    @(negedge clock);
    checkOutput("clr_hold", obs_w0, obs_t'('0));
    clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checkOutput($sformatf("clr_idle[%0d]", i), obs_w0, obs_t'('0));
    end

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Hardwired control sequencer for the Phase-1 CPU datapath.
- Drives the same strobe set the directed benches drive by hand: fetch steps T0–T2, then a decoded execute sequence for register-register ALU, unary and MUL/DIV instructions.
- Sits between a run/step controller and the CPU datapath.
- Reads the IR contents and emits one-hot register enables plus the ALU opcode.

Parameters:
- MEM_WAIT, 0, extra cycles T1 holds memRead/MDRin; range 0–7.

Ports:
- clock  in  1  system clock, rising-edge.
- clear  in  1  asynchronous, active-high reset.
- start  in  1  begin one instruction; sampled only in IDLE.
- ir  in  32  IR register contents; fields are opcode = ir[31:27], Ra = ir[26:23], Rb = ir[22:19], Rc = ir[18:15].
- PCout, MARin, IncPC  out  1 each  fetch strobes.
- memRead, MDRin, MDRout, IRin  out  1 each  memory/IR strobes.
- Yin, Zin, Zhighout, Zlowout, HIin, LOin  out  1 each  ALU path strobes.
- Rout  out  16  one-hot register read enable; bit n drives Rnout.
- Rin  out  16  one-hot register write enable; bit n drives Rnin.
- alu_op  out  5  ALU operation; equals the opcode during execute, 0 otherwise.
- done  out  1  one-cycle pulse when the instruction completes.
- illegal  out  1  one-cycle pulse on an unsupported opcode.

Behaviour:
- Moore FSM. All outputs decode from the registered state and `ir`.
- clear forces IDLE immediately, including mid-instruction. While in reset and in IDLE, every output is 0 (Rin = Rout = 0, alu_op = 0, done = illegal = 0).
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, DONE.
- IDLE: when start = 1 at a rising edge, go to T0; otherwise stay.
- T0: PCout = MARin = IncPC = 1; go to T1.
- T1: memRead = MDRin = 1. A wait counter loads MEM_WAIT on entry; stay in T1 while the counter is nonzero, decrementing each cycle. Go to T2 when it reaches 0. With MEM_WAIT = 0, T1 lasts exactly 1 cycle.
- T2: MDRout = IRin = 1; go to T3. IR updates on the edge leaving T2. `ir` is stable from T3 until return to IDLE.
- T3 decode, by opcode class:
  - Three-operand (00011 add, 00100 sub, 00101 and, 00110 or, 00111 ror, 01000 rol, 01001 shr, 01010 shra, 01011 shl):
    - T3: Rout[Rb] = 1, Yin = 1.
    - T4: Rout[Rc] = 1, Zin = 1, alu_op = opcode.
    - T5: Zlowout = 1, Rin[Ra] = 1.
    - Then DONE.
  - Unary (10001 neg, 10010 not):
    - T3: Rout[Rb] = 1, Zin = 1, alu_op = opcode.
    - T4: Zlowout = 1, Rin[Ra] = 1.
    - Then DONE.
  - MUL/DIV (10000 mul, 01111 div):
    - T3: Rout[Ra] = 1, Yin = 1.
    - T4: Rout[Rb] = 1, Zin = 1, alu_op = opcode.
    - T5: Zlowout = 1, LOin = 1.
    - T6: Zhighout = 1, HIin = 1.
    - Then DONE.
  - Any other opcode: illegal = 1 during T3, no datapath strobes; next state IDLE, done is not pulsed.
- DONE: done = 1 for one cycle, then IDLE. start is ignored in DONE; a new instruction needs start in IDLE.
- Invariants:
  - At most one Rout bit and at most one Rin bit is set per cycle.
  - Never assert Zin and Yin in the same cycle.
  - Never assert Zlowout and Zhighout in the same cycle.
- Ra = Rb (e.g. neg R3, R3) is legal: the source is read in T3 and written in the last step.
- Latency (MEM_WAIT = 0, start high in cycle c): T0 at c+1. DONE is at c+6 for unary, c+7 for three-operand, c+8 for MUL/DIV. Each unit of MEM_WAIT adds 1.

Test Plan:
- NEG: MEM_WAIT = 0, ir = 0x8B38_0000 (neg R6, R7), start pulse.
  - T3: Rout = 0x0080, Zin = 1, alu_op = 5'b10001.
  - T4: Zlowout = 1, Rin = 0x0040.
  - done high exactly 6 cycles after start.
- ADD: ir = 0x1891_8000 (add R1, R2, R3).
  - T3: Rout = 0x0004, Yin = 1.
  - T4: Rout = 0x0008, Zin = 1, alu_op = 5'b00011.
  - T5: Rin = 0x0002, Zlowout = 1.
  - done at start+7.
- MUL: ir = 0x8228_0000 (mul R4, R5).
  - T3: Rout = 0x0010, Yin = 1.
  - T4: Rout = 0x0020, Zin = 1, alu_op = 5'b10000.
  - T5: LOin = 1, Zlowout = 1.
  - T6: HIin = 1, Zhighout = 1.
  - done at start+8; Rin = 0 throughout.
- Illegal: ir = 0xF800_0000.
  - illegal pulses at start+4; no Rin/Zin/Yin ever.
  - done stays 0; FSM is back in IDLE at start+5.
- MEM_WAIT = 2 with NEG: memRead/MDRin high for 3 consecutive cycles; done at start+8.
- Reset and start gating:
  - Assert clear asynchronously mid-T4 of ADD: all outputs 0 immediately; IDLE after release; no Rin pulse.
  - start held high through DONE: exactly one instruction per IDLE entry.
